// File: rtl/gonsolo_pkg.sv
// Shared definitions for the gonsolo reset sequencer / watchdog:
// controller state encoding, tick counter width and a ceil-log2 helper.
package gonsolo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEQ     = 2'd1,
        RUN     = 2'd2,
        TIMEOUT = 2'd3
    } wdt_state_t;

    localparam int TICK_CNT_W = 8;

    // Number of bits needed to count 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gonsolo_reset_watchdog_if.sv
// Control/status bundle between the gonsolo reset watchdog (slave side)
// and whatever enables, kicks and observes it (master side).
interface gonsolo_reset_watchdog_if #(
    parameter int NUM_RST = 3
);
    import gonsolo_pkg::*;

    logic                  enable;
    logic                  kick;
    logic [NUM_RST-1:0]    rst_n_out;
    logic                  seq_done;
    logic                  tick;
    logic [TICK_CNT_W-1:0] tick_cnt;
    logic                  timeout;
    logic [TICK_CNT_W-1:0] restart_cnt;

    modport master (
        output enable,
        output kick,
        input  rst_n_out,
        input  seq_done,
        input  tick,
        input  tick_cnt,
        input  timeout,
        input  restart_cnt
    );

    modport slave (
        input  enable,
        input  kick,
        output rst_n_out,
        output seq_done,
        output tick,
        output tick_cnt,
        output timeout,
        output restart_cnt
    );

endinterface

// File: rtl/gonsolo_reset_sync.sv
// Two-flop reset synchroniser: assertion follows resetb immediately,
// release reaches rst_sync_n on the second clock edge after resetb rises.
module gonsolo_reset_sync (
    input  logic clock,
    input  logic resetb,
    output logic rst_sync_n
);

    logic meta;

    // Shift a constant 1 through two flops once resetb is released.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            meta       <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_sync_n <= meta;
        end
    end

endmodule

// File: rtl/gonsolo_reset_watchdog.sv
// Power-on reset sequencer and cycle watchdog for the gonsolo user project.
// Releases NUM_RST active-low resets one by one, then counts ticks of
// TICK_PERIOD cycles and times out after TICK_LIMIT ticks without a kick.
// Optional macro GONSOLO_WDT_AUTO_RESTART_EN: when defined, TIMEOUT lasts
// one cycle and the block restarts the release sequence; when undefined,
// TIMEOUT is sticky until resetb and restart_cnt stays 0.
module gonsolo_reset_watchdog
    import gonsolo_pkg::*;
#(
    parameter int NUM_RST        = 3,
    parameter int STAGGER_CYCLES = 4,
    parameter int TICK_PERIOD    = 1000,
    parameter int TICK_LIMIT     = 10
) (
    input  logic clock,
    input  logic resetb,
    gonsolo_reset_watchdog_if.slave wdt
);

    localparam int SEQ_LAST = STAGGER_CYCLES * NUM_RST;
    localparam int SEQ_W    = clog2(SEQ_LAST + 1);
    localparam int CYC_W    = clog2(TICK_PERIOD);

    localparam logic [SEQ_W-1:0]      SEQ_END  = SEQ_W'(SEQ_LAST);
    localparam logic [CYC_W-1:0]      CYC_LAST = CYC_W'(TICK_PERIOD - 1);
    localparam logic [TICK_CNT_W-1:0] TICK_MAX = TICK_CNT_W'(TICK_LIMIT);

    logic                  rst_sync_n;
    wdt_state_t            state;
    logic [SEQ_W-1:0]      seq_cnt;
    logic [SEQ_W-1:0]      seq_next;
    logic [NUM_RST-1:0]    release_mask;
    logic [CYC_W-1:0]      cyc_cnt;
    logic [NUM_RST-1:0]    rst_q;
    logic                  seq_done_q;
    logic                  tick_q;
    logic [TICK_CNT_W-1:0] tick_cnt_q;
    logic                  timeout_q;

    gonsolo_reset_sync u_reset_sync (
        .clock      (clock),
        .resetb     (resetb),
        .rst_sync_n (rst_sync_n)
    );

    // Channels whose release point has been reached on the coming edge.
    always_comb begin
        seq_next     = seq_cnt + SEQ_W'(1);
        release_mask = '0;
        for (int i = 0; i < NUM_RST; i++) begin
            if (int'(seq_next) >= STAGGER_CYCLES * (i + 1)) begin
                release_mask[i] = 1'b1;
            end
        end
    end

    // Main controller: sequencing, tick counting, timeout, all outputs registered.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state      <= IDLE;
            seq_cnt    <= '0;
            cyc_cnt    <= '0;
            rst_q      <= '0;
            seq_done_q <= 1'b0;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if ((state == SEQ || state == RUN) && !wdt.enable) begin
                state      <= IDLE;
                seq_cnt    <= '0;
                cyc_cnt    <= '0;
                rst_q      <= '0;
                seq_done_q <= 1'b0;
                tick_cnt_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        seq_cnt    <= '0;
                        cyc_cnt    <= '0;
                        rst_q      <= '0;
                        seq_done_q <= 1'b0;
                        tick_cnt_q <= '0;
                        timeout_q  <= 1'b0;
                        if (wdt.enable) begin
                            state <= SEQ;
                        end
                    end
                    SEQ: begin
                        seq_cnt <= seq_next;
                        rst_q   <= rst_q | release_mask;
                        if (seq_next == SEQ_END) begin
                            state      <= RUN;
                            seq_done_q <= 1'b1;
                            cyc_cnt    <= '0;
                            tick_cnt_q <= '0;
                        end
                    end
                    RUN: begin
                        if (wdt.kick) begin
                            cyc_cnt    <= '0;
                            tick_cnt_q <= '0;
                        end else if (tick_cnt_q == TICK_MAX) begin
                            state      <= TIMEOUT;
                            timeout_q  <= 1'b1;
                            rst_q      <= '0;
                            seq_done_q <= 1'b0;
                        end else if (cyc_cnt == CYC_LAST) begin
                            cyc_cnt    <= '0;
                            tick_q     <= 1'b1;
                            tick_cnt_q <= tick_cnt_q + TICK_CNT_W'(1);
                        end else begin
                            cyc_cnt <= cyc_cnt + CYC_W'(1);
                        end
                    end
                    TIMEOUT: begin
`ifdef GONSOLO_WDT_AUTO_RESTART_EN
                        timeout_q  <= 1'b0;
                        tick_cnt_q <= '0;
                        cyc_cnt    <= '0;
                        seq_cnt    <= '0;
                        state      <= wdt.enable ? SEQ : IDLE;
`else
                        state <= TIMEOUT;
`endif
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef GONSOLO_WDT_AUTO_RESTART_EN
    logic [TICK_CNT_W-1:0] restart_q;

    // Count restarts taken on each TIMEOUT exit, saturating at all-ones.
    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            restart_q <= '0;
        end else if (state == TIMEOUT && restart_q != '1) begin
            restart_q <= restart_q + TICK_CNT_W'(1);
        end
    end

    assign wdt.restart_cnt = restart_q;
`else
    assign wdt.restart_cnt = '0;
`endif

    assign wdt.rst_n_out = rst_q;
    assign wdt.seq_done  = seq_done_q;
    assign wdt.tick      = tick_q;
    assign wdt.tick_cnt  = tick_cnt_q;
    assign wdt.timeout   = timeout_q;

endmodule
